equiv_lockstep_checker: RTL and testbench
=========================================

EQUIV_LOCKSTEP_CHECKER -- requirements
Module: equiv_lockstep_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 91, bit width of one lane of each design output.
REQ-002 SHALL have parameter LANES, default 2, number of independent compared lanes (1..16).
REQ-003 SHALL have parameter ALIGN_A, default 0, pipeline delay applied to y_a (0..8 cycles).
REQ-004 SHALL have parameter ALIGN_B, default 0, pipeline delay applied to y_b (0..8 cycles).
REQ-005 SHALL have parameter CNT_W, default 16, width of the mismatch and cycle counters.
REQ-006 SHALL have parameter STOP_ON_FAIL, default 1; 1 freezes checking at the first mismatch.
REQ-007 SHALL have one clock and an asynchronous, active-low reset.
REQ-008 SHALL have port clk, input, 1, rising-edge clock.
REQ-009 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port arm, input, 1, starts a check run from IDLE.
REQ-011 SHALL have port clear, input, 1, synchronous return to IDLE that wipes all results.
REQ-012 SHALL have port lane_mask, input, LANES, 1 excludes that lane from comparison.
REQ-013 SHALL have port y_a, input, LANES*WIDTH, design-1 outputs; lane i = [i*WIDTH +: WIDTH].
REQ-014 SHALL have port y_b, input, LANES*WIDTH, design-2 outputs, same lane packing.
REQ-015 SHALL have port state, output, 2, current state: IDLE=0, WARMUP=1, CHECK=2, FAIL=3.
REQ-016 SHALL have port mismatch, output, 1, registered per-cycle mismatch pulse.
REQ-017 SHALL have port mismatch_lanes, output, LANES, registered per-lane mismatch flags.
REQ-018 SHALL have port err_sticky, output, 1, set by the first mismatch and held.
REQ-019 SHALL have port mismatch_cnt, output, CNT_W, saturating count of mismatching cycles.
REQ-020 SHALL have port cycle_cnt, output, CNT_W, saturating count of compared cycles.
REQ-021 SHALL have ports first_lane (output, 4), first_cycle (output, CNT_W), first_a (output, WIDTH) and first_b (output, WIDTH), capturing the first mismatch.

Function
REQ-022 SHALL compare in cycle c the aligned values a_d = y_a(c-ALIGN_A) and b_d = y_b(c-ALIGN_B); a delay of 0 means the value sampled at the current edge.
REQ-023 SHALL perform comparisons only in CHECK; a lane mismatches when a_d != b_d in that lane and its lane_mask bit is 0; lane_mask is applied at compare time.
REQ-024 SHALL register mismatch_lanes and mismatch one cycle after the compare, with mismatch = OR of mismatch_lanes; both are 0 outside CHECK compares.
REQ-025 SHALL go IDLE->WARMUP on arm and load the warmup counter with max(ALIGN_A, ALIGN_B); WARMUP SHALL last that value plus 1 cycles, then go to CHECK.
REQ-026 SHALL ignore arm while in WARMUP, CHECK or FAIL.
REQ-027 SHALL increment cycle_cnt once per CHECK cycle and mismatch_cnt once per mismatching cycle regardless of how many lanes differ; both saturate at 2^CNT_W-1.
REQ-028 SHALL, on the first mismatch since arm, load first_lane with the lowest mismatching lane index, first_cycle with the pre-increment cycle_cnt, and first_a/first_b with that lane's a_d/b_d; these are held until clear or reset.
REQ-029 SHALL, when STOP_ON_FAIL=1, go CHECK->FAIL on the first mismatch; in FAIL there are no compares, counters freeze and mismatch returns to 0.
REQ-030 SHALL, when STOP_ON_FAIL=0, stay in CHECK, keep counting, and leave the first_* captures unchanged.
REQ-031 SHALL, on clear, return to IDLE from any state and zero counters, err_sticky, mismatch* and first_*; clear SHALL take priority over arm in the same cycle.
REQ-032 SHALL not clear the alignment delay lines on clear; WARMUP refills them before compares.

Reset
REQ-033 SHALL force on rst_n low, asynchronously: state=IDLE, and all outputs, counters, captures and delay-line registers to 0.
REQ-034 SHALL, on rst_n deassertion, wait for arm; a reset mid-run aborts the run with no residual results.

Verification
REQ-035 Bench SHALL cover: defaults, arm, identical y for 10 cycles -> state=2, cycle_cnt=10, mismatch_cnt=0, err_sticky=0.
REQ-036 Bench SHALL cover: STOP_ON_FAIL=1, lanes 0 and 1 differ on CHECK cycle 5 -> mismatch pulse, first_lane=0, first_cycle=5, state=3, counters frozen.
REQ-037 Bench SHALL cover: ALIGN_A=3, ALIGN_B=1, y_b equal to y_a delayed 2 cycles -> WARMUP lasts 4 cycles, no mismatches.
REQ-038 Bench SHALL cover: STOP_ON_FAIL=0, CNT_W=4, 20 mismatching cycles -> mismatch_cnt=15, first_* equal to the first-cycle values.
REQ-039 Bench SHALL cover: lane_mask=2'b10, lane 1 differs -> no mismatch; arm and clear in the same cycle -> IDLE.
REQ-040 Bench SHALL cover: rst_n low mid-CHECK -> all outputs immediately 0, state=0.

Source files
------------

// File: rtl/equiv_lockstep_checker.sv
// Lockstep equivalence checker: aligns two design output buses and compares them lane by lane.
// It tracks the mismatch and compare counts and captures the first mismatch seen after arm.
module equiv_lockstep_checker #(
  parameter int WIDTH        = 91,
  parameter int LANES        = 2,
  parameter int ALIGN_A      = 0,
  parameter int ALIGN_B      = 0,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     clear,
  input  logic [LANES-1:0]         lane_mask,
  input  logic [LANES*WIDTH-1:0]   y_a,
  input  logic [LANES*WIDTH-1:0]   y_b,
  output logic [1:0]               state,
  output logic                     mismatch,
  output logic [LANES-1:0]         mismatch_lanes,
  output logic                     err_sticky,
  output logic [CNT_W-1:0]         mismatch_cnt,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [3:0]               first_lane,
  output logic [CNT_W-1:0]         first_cycle,
  output logic [WIDTH-1:0]         first_a,
  output logic [WIDTH-1:0]         first_b
);

  localparam int          WARM      = (ALIGN_A > ALIGN_B) ? ALIGN_A : ALIGN_B;
  localparam logic [3:0]  WARM_LOAD = 4'(WARM);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_CHECK  = 2'd2,
    S_FAIL   = 2'd3
  } state_t;

  state_t                   r_state, w_state_next;
  logic [3:0]               r_warm, w_warm_next;
  logic [LANES*WIDTH-1:0]   w_a_d, w_b_d;
  logic [LANES-1:0]         w_lane_mm;
  logic                     w_check, w_any;
  logic [3:0]               w_first_lane;
  logic [WIDTH-1:0]         w_first_a, w_first_b;

  logic                     r_mm;
  logic [LANES-1:0]         r_mm_lanes;
  logic                     r_err;
  logic [CNT_W-1:0]         r_mm_cnt, r_cycle_cnt, r_first_cycle;
  logic [3:0]               r_first_lane;
  logic [WIDTH-1:0]         r_first_a, r_first_b;

  // Delay lines run continuously (clear leaves them alone) so WARMUP only has to outlast the deeper one.
  generate
    if (ALIGN_A == 0) begin : g_a_direct
      assign w_a_d = y_a;
    end else begin : g_a_delay
      logic [LANES*WIDTH-1:0] r_dly [ALIGN_A];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < ALIGN_A; i++) r_dly[i] <= '0;
        end else begin
          r_dly[0] <= y_a;
          for (int i = 1; i < ALIGN_A; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign w_a_d = r_dly[ALIGN_A-1];
    end

    if (ALIGN_B == 0) begin : g_b_direct
      assign w_b_d = y_b;
    end else begin : g_b_delay
      logic [LANES*WIDTH-1:0] r_dly [ALIGN_B];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < ALIGN_B; i++) r_dly[i] <= '0;
        end else begin
          r_dly[0] <= y_b;
          for (int i = 1; i < ALIGN_B; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign w_b_d = r_dly[ALIGN_B-1];
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_mm[gi] = (w_a_d[gi*WIDTH +: WIDTH] != w_b_d[gi*WIDTH +: WIDTH]) && !lane_mask[gi];
    end
  endgenerate

  assign w_check = (r_state == S_CHECK);
  assign w_any   = w_check && (|w_lane_mm);

  // Walk downwards so the lowest mismatching lane wins.
  always_comb begin
    w_first_lane = '0;
    w_first_a    = '0;
    w_first_b    = '0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (w_lane_mm[i]) begin
        w_first_lane = i[3:0];
        w_first_a    = w_a_d[i*WIDTH +: WIDTH];
        w_first_b    = w_b_d[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_warm  <= '0;
    end else begin
      r_state <= w_state_next;
      r_warm  <= w_warm_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_warm_next  = r_warm;
    if (clear) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            w_state_next = S_WARMUP;
            w_warm_next  = WARM_LOAD;
          end
        end
        S_WARMUP: begin
          if (r_warm == 4'd0) w_state_next = S_CHECK;
          else                w_warm_next  = r_warm - 4'd1;
        end
        S_CHECK: begin
          if (w_any && (STOP_ON_FAIL != 0)) w_state_next = S_FAIL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mm          <= 1'b0;
      r_mm_lanes    <= '0;
      r_err         <= 1'b0;
      r_mm_cnt      <= '0;
      r_cycle_cnt   <= '0;
      r_first_cycle <= '0;
      r_first_lane  <= '0;
      r_first_a     <= '0;
      r_first_b     <= '0;
    end else if (clear) begin
      r_mm          <= 1'b0;
      r_mm_lanes    <= '0;
      r_err         <= 1'b0;
      r_mm_cnt      <= '0;
      r_cycle_cnt   <= '0;
      r_first_cycle <= '0;
      r_first_lane  <= '0;
      r_first_a     <= '0;
      r_first_b     <= '0;
    end else begin
      r_mm       <= w_any;
      r_mm_lanes <= w_check ? w_lane_mm : '0;
      if (w_check) begin
        if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        if (w_any) begin
          if (r_mm_cnt != '1) r_mm_cnt <= r_mm_cnt + CNT_W'(1);
          // Only one run exists between clears, so err_sticky doubles as "already captured".
          if (!r_err) begin
            r_err         <= 1'b1;
            r_first_lane  <= w_first_lane;
            r_first_cycle <= r_cycle_cnt;
            r_first_a     <= w_first_a;
            r_first_b     <= w_first_b;
          end
        end
      end
    end
  end

  assign state          = r_state;
  assign mismatch       = r_mm;
  assign mismatch_lanes = r_mm_lanes;
  assign err_sticky     = r_err;
  assign mismatch_cnt   = r_mm_cnt;
  assign cycle_cnt      = r_cycle_cnt;
  assign first_lane     = r_first_lane;
  assign first_cycle    = r_first_cycle;
  assign first_a        = r_first_a;
  assign first_b        = r_first_b;

endmodule

// File: tb/tb_equiv_lockstep_checker.sv
// Bench for equiv_lockstep_checker: three instances (defaults, skewed alignment, non-stopping 4-bit
// counters) driven with random buses and compared every cycle against a timeline-based reference model.
module tb_equiv_lockstep_checker;
  localparam int W  = 91;
  localparam int L  = 2;
  localparam int YW = W*L;
  localparam int NI = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic            arm_v   [NI];
  logic            clear_v [NI];
  logic [L-1:0]    mask_v  [NI];
  logic [YW-1:0]   ya_v    [NI];
  logic [YW-1:0]   yb_v    [NI];

  logic [1:0]      st_o   [NI];
  logic            mm_o   [NI];
  logic [L-1:0]    mml_o  [NI];
  logic            err_o  [NI];
  logic [15:0]     mmc_o  [NI];
  logic [15:0]     cyc_o  [NI];
  logic [15:0]     fcyc_o [NI];
  logic [3:0]      fl_o   [NI];
  logic [W-1:0]    fa_o   [NI];
  logic [W-1:0]    fb_o   [NI];
  logic [3:0]      mmc2, cyc2, fcyc2;

  assign mmc_o[2]  = {12'd0, mmc2};
  assign cyc_o[2]  = {12'd0, cyc2};
  assign fcyc_o[2] = {12'd0, fcyc2};

  always #5 clk = ~clk;

  equiv_lockstep_checker #(.WIDTH(W), .LANES(L), .ALIGN_A(0), .ALIGN_B(0), .CNT_W(16), .STOP_ON_FAIL(1)) u0 (
    .clk(clk), .rst_n(rst_n), .arm(arm_v[0]), .clear(clear_v[0]), .lane_mask(mask_v[0]),
    .y_a(ya_v[0]), .y_b(yb_v[0]), .state(st_o[0]), .mismatch(mm_o[0]), .mismatch_lanes(mml_o[0]),
    .err_sticky(err_o[0]), .mismatch_cnt(mmc_o[0]), .cycle_cnt(cyc_o[0]), .first_lane(fl_o[0]),
    .first_cycle(fcyc_o[0]), .first_a(fa_o[0]), .first_b(fb_o[0]));

  equiv_lockstep_checker #(.WIDTH(W), .LANES(L), .ALIGN_A(3), .ALIGN_B(1), .CNT_W(16), .STOP_ON_FAIL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .arm(arm_v[1]), .clear(clear_v[1]), .lane_mask(mask_v[1]),
    .y_a(ya_v[1]), .y_b(yb_v[1]), .state(st_o[1]), .mismatch(mm_o[1]), .mismatch_lanes(mml_o[1]),
    .err_sticky(err_o[1]), .mismatch_cnt(mmc_o[1]), .cycle_cnt(cyc_o[1]), .first_lane(fl_o[1]),
    .first_cycle(fcyc_o[1]), .first_a(fa_o[1]), .first_b(fb_o[1]));

  equiv_lockstep_checker #(.WIDTH(W), .LANES(L), .ALIGN_A(0), .ALIGN_B(0), .CNT_W(4), .STOP_ON_FAIL(0)) u2 (
    .clk(clk), .rst_n(rst_n), .arm(arm_v[2]), .clear(clear_v[2]), .lane_mask(mask_v[2]),
    .y_a(ya_v[2]), .y_b(yb_v[2]), .state(st_o[2]), .mismatch(mm_o[2]), .mismatch_lanes(mml_o[2]),
    .err_sticky(err_o[2]), .mismatch_cnt(mmc2), .cycle_cnt(cyc2), .first_lane(fl_o[2]),
    .first_cycle(fcyc2), .first_a(fa_o[2]), .first_b(fb_o[2]));

  // Reference model: per-instance parameters plus a timeline of when the run was armed.
  int m_ala [NI] = '{0, 3, 0};
  int m_alb [NI] = '{0, 1, 0};
  int m_max [NI] = '{65535, 65535, 15};
  int m_sof [NI] = '{1, 1, 0};
  int m_armed [NI], m_tarm [NI], m_failed [NI], m_err [NI];
  int m_cyc [NI], m_mmc [NI], m_fl [NI], m_fcyc [NI];
  logic          m_mm  [NI];
  logic [L-1:0]  m_mml [NI];
  logic [W-1:0]  m_fa  [NI];
  logic [W-1:0]  m_fb  [NI];
  logic [YW-1:0] m_ha  [NI][9];
  logic [YW-1:0] m_hb  [NI][9];
  int n_edge = 0;

  int n_checks = 0;
  int n_errors = 0;
  int kind_v [NI];
  logic hold_v [NI];
  logic [YW-1:0] u1_hist [2];
  int warm1_seen = 0;
  logic [W-1:0] rec_a, rec_b;

  task automatic check_val(string tag, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [YW-1:0] rnd_y();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[YW-1:0];
  endfunction

  function automatic logic [YW-1:0] lane_flip(int lane);
    logic [YW-1:0] f;
    f = '0;
    f[lane*W + int'($urandom_range(W-1, 0))] = 1'b1;
    return f;
  endfunction

  function automatic int warm_len(int k);
    return (m_ala[k] > m_alb[k]) ? m_ala[k] : m_alb[k];
  endfunction

  // Armed at edge t with depth D: WARMUP after edges t..t+D, compares from edge t+D+2 on.
  function automatic int exp_state(int k);
    if (m_armed[k] == 0) return 0;
    if (m_failed[k] != 0) return 3;
    if (n_edge < m_tarm[k] + warm_len(k) + 1) return 1;
    return 2;
  endfunction

  task automatic model_clear(int k);
    m_armed[k] = 0; m_tarm[k] = 0; m_failed[k] = 0; m_err[k] = 0;
    m_cyc[k] = 0; m_mmc[k] = 0; m_fl[k] = 0; m_fcyc[k] = 0;
    m_mm[k] = 1'b0; m_mml[k] = '0; m_fa[k] = '0; m_fb[k] = '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      model_clear(k);
      for (int j = 0; j < 9; j++) begin
        m_ha[k][j] = '0;
        m_hb[k][j] = '0;
      end
    end
    u1_hist[0] = '0;
    u1_hist[1] = '0;
  endtask

  task automatic model_edge(int k);
    logic [YW-1:0] a_d, b_d;
    logic [L-1:0]  lm;
    a_d = (m_ala[k] == 0) ? ya_v[k] : m_ha[k][m_ala[k]-1];
    b_d = (m_alb[k] == 0) ? yb_v[k] : m_hb[k][m_alb[k]-1];
    for (int j = 8; j > 0; j--) begin
      m_ha[k][j] = m_ha[k][j-1];
      m_hb[k][j] = m_hb[k][j-1];
    end
    m_ha[k][0] = ya_v[k];
    m_hb[k][0] = yb_v[k];
    if (clear_v[k]) begin
      model_clear(k);
    end else begin
      m_mm[k]  = 1'b0;
      m_mml[k] = '0;
      if (m_armed[k] != 0 && m_failed[k] == 0 && n_edge >= m_tarm[k] + warm_len(k) + 2) begin
        lm = '0;
        for (int j = 0; j < L; j++)
          if (a_d[j*W +: W] != b_d[j*W +: W] && !mask_v[k][j]) lm[j] = 1'b1;
        m_mml[k] = lm;
        m_mm[k]  = |lm;
        if (lm != '0) begin
          if (m_err[k] == 0) begin
            m_err[k]  = 1;
            m_fl[k]   = lm[0] ? 0 : 1;
            m_fa[k]   = a_d[m_fl[k]*W +: W];
            m_fb[k]   = b_d[m_fl[k]*W +: W];
            m_fcyc[k] = m_cyc[k];
          end
          if (m_mmc[k] < m_max[k]) m_mmc[k]++;
          if (m_sof[k] != 0) m_failed[k] = 1;
        end
        if (m_cyc[k] < m_max[k]) m_cyc[k]++;
      end
      if (m_armed[k] == 0 && arm_v[k]) begin
        m_armed[k] = 1;
        m_tarm[k]  = n_edge;
      end
    end
  endtask

  task automatic check_all(int k);
    check_val($sformatf("u%0d.state", k),          128'(st_o[k]),   128'(exp_state(k)));
    check_val($sformatf("u%0d.mismatch", k),       128'(mm_o[k]),   128'(m_mm[k]));
    check_val($sformatf("u%0d.mismatch_lanes", k), 128'(mml_o[k]),  128'(m_mml[k]));
    check_val($sformatf("u%0d.err_sticky", k),     128'(err_o[k]),  128'(m_err[k] != 0));
    check_val($sformatf("u%0d.mismatch_cnt", k),   128'(mmc_o[k]),  128'(m_mmc[k]));
    check_val($sformatf("u%0d.cycle_cnt", k),      128'(cyc_o[k]),  128'(m_cyc[k]));
    check_val($sformatf("u%0d.first_lane", k),     128'(fl_o[k]),   128'(m_fl[k]));
    check_val($sformatf("u%0d.first_cycle", k),    128'(fcyc_o[k]), 128'(m_fcyc[k]));
    check_val($sformatf("u%0d.first_a", k),        128'(fa_o[k]),   128'(m_fa[k]));
    check_val($sformatf("u%0d.first_b", k),        128'(fb_o[k]),   128'(m_fb[k]));
  endtask

  // kind 0: equal buses, 1: occasional lane differences, 2: at least one lane differs every cycle.
  task automatic fill(int k);
    logic [YW-1:0] f;
    ya_v[k] = rnd_y();
    f = '0;
    if (kind_v[k] == 1) begin
      for (int j = 0; j < L; j++)
        if ($urandom_range(3, 0) == 0) f = f ^ lane_flip(j);
    end else if (kind_v[k] == 2) begin
      f = lane_flip(int'($urandom_range(L-1, 0)));
      if ($urandom_range(1, 0) == 1) f = f | lane_flip(int'($urandom_range(L-1, 0)));
    end
    yb_v[k] = ya_v[k] ^ f;
  endtask

  // Caller sets inputs while clk is low; one rising edge is taken and every instance is checked.
  task automatic step();
    for (int k = 0; k < NI; k++) begin
      if (!hold_v[k]) begin
        if (k == 1) begin
          ya_v[1] = rnd_y();
          yb_v[1] = u1_hist[1];
        end else begin
          fill(k);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      model_edge(k);
      check_all(k);
      hold_v[k] = 1'b0;
    end
    if (st_o[1] == 2'd1) warm1_seen++;
    u1_hist[1] = u1_hist[0];
    u1_hist[0] = ya_v[1];
    n_edge++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < NI; k++) begin
      arm_v[k] = 1'b0; clear_v[k] = 1'b0; mask_v[k] = '0; kind_v[k] = 0; hold_v[k] = 1'b0;
    end
  endtask

  initial begin
    idle_inputs();
    for (int k = 0; k < NI; k++) begin
      ya_v[k] = '0;
      yb_v[k] = '0;
    end
    model_reset();
    #2;
    for (int k = 0; k < NI; k++) check_all(k);
    @(negedge clk);
    rst_n = 1'b1;

    // Equal buses on u0 for 10 compares; u1 armed alongside with y_b = y_a delayed by 2.
    arm_v[0] = 1'b1; arm_v[1] = 1'b1;
    step();
    arm_v[0] = 1'b0; arm_v[1] = 1'b0;
    repeat (11) step();
    check_val("s035.state", 128'(st_o[0]), 128'd2);
    check_val("s035.cycle_cnt", 128'(cyc_o[0]), 128'd10);
    check_val("s035.mismatch_cnt", 128'(mmc_o[0]), 128'd0);
    check_val("s035.err_sticky", 128'(err_o[0]), 128'd0);
    check_val("s037.warmup_cycles", 128'(warm1_seen), 128'd4);
    check_val("s037.state", 128'(st_o[1]), 128'd2);
    check_val("s037.mismatch_cnt", 128'(mmc_o[1]), 128'd0);
    $display("txn equal-run: u0 state=%0d cycle_cnt=%0d, u1 warmup_cycles=%0d", st_o[0], cyc_o[0], warm1_seen);

    // Stop-on-fail: both lanes differ on compare index 5.
    clear_v[0] = 1'b1; step(); clear_v[0] = 1'b0;
    arm_v[0] = 1'b1; step(); arm_v[0] = 1'b0;
    repeat (6) step();
    ya_v[0] = rnd_y();
    yb_v[0] = ya_v[0] ^ lane_flip(0) ^ lane_flip(1);
    rec_a = ya_v[0][W-1:0];
    rec_b = yb_v[0][W-1:0];
    hold_v[0] = 1'b1;
    step();
    check_val("s036.mismatch", 128'(mm_o[0]), 128'd1);
    check_val("s036.mismatch_lanes", 128'(mml_o[0]), 128'd3);
    check_val("s036.first_lane", 128'(fl_o[0]), 128'd0);
    check_val("s036.first_cycle", 128'(fcyc_o[0]), 128'd5);
    check_val("s036.first_a", 128'(fa_o[0]), 128'(rec_a));
    check_val("s036.first_b", 128'(fb_o[0]), 128'(rec_b));
    check_val("s036.state", 128'(st_o[0]), 128'd3);
    kind_v[0] = 2;
    repeat (5) step();
    kind_v[0] = 0;
    check_val("s036.frozen_cycle_cnt", 128'(cyc_o[0]), 128'd6);
    check_val("s036.frozen_mismatch_cnt", 128'(mmc_o[0]), 128'd1);
    check_val("s036.pulse_gone", 128'(mm_o[0]), 128'd0);
    $display("txn stop-on-fail: state=%0d first_lane=%0d first_cycle=%0d", st_o[0], fl_o[0], fcyc_o[0]);

    // Non-stopping run on u2: 20 mismatching compares saturate the 4-bit counters.
    arm_v[2] = 1'b1; step(); arm_v[2] = 1'b0;
    step();
    ya_v[2] = rnd_y();
    yb_v[2] = ya_v[2] ^ lane_flip(1);
    rec_a = ya_v[2][W +: W];
    rec_b = yb_v[2][W +: W];
    hold_v[2] = 1'b1;
    step();
    kind_v[2] = 2;
    repeat (19) step();
    kind_v[2] = 0;
    check_val("s038.mismatch_cnt", 128'(mmc_o[2]), 128'd15);
    check_val("s038.cycle_cnt", 128'(cyc_o[2]), 128'd15);
    check_val("s038.state", 128'(st_o[2]), 128'd2);
    check_val("s038.first_lane", 128'(fl_o[2]), 128'd1);
    check_val("s038.first_cycle", 128'(fcyc_o[2]), 128'd0);
    check_val("s038.first_a", 128'(fa_o[2]), 128'(rec_a));
    check_val("s038.first_b", 128'(fb_o[2]), 128'(rec_b));
    $display("txn saturate: mismatch_cnt=%0d cycle_cnt=%0d", mmc_o[2], cyc_o[2]);

    // Masked lane 1 differs every compare; then arm+clear together from CHECK.
    clear_v[0] = 1'b1; step(); clear_v[0] = 1'b0;
    mask_v[0] = 2'b10;
    arm_v[0] = 1'b1; step(); arm_v[0] = 1'b0;
    step();
    repeat (8) begin
      ya_v[0] = rnd_y();
      yb_v[0] = ya_v[0] ^ lane_flip(1);
      hold_v[0] = 1'b1;
      step();
      check_val("s039.mismatch", 128'(mm_o[0]), 128'd0);
    end
    check_val("s039.cycle_cnt", 128'(cyc_o[0]), 128'd8);
    check_val("s039.err_sticky", 128'(err_o[0]), 128'd0);
    arm_v[0] = 1'b1; clear_v[0] = 1'b1;
    step();
    arm_v[0] = 1'b0; clear_v[0] = 1'b0;
    check_val("s039.arm_clear_state", 128'(st_o[0]), 128'd0);
    step();
    check_val("s039.still_idle", 128'(st_o[0]), 128'd0);
    mask_v[0] = '0;
    $display("txn masked: cycle_cnt before clear=8, state now=%0d", st_o[0]);

    // Random arm/clear/mask traffic on every instance.
    for (int s = 0; s < 300; s++) begin
      for (int k = 0; k < NI; k++) begin
        arm_v[k]   = ($urandom_range(9, 0) == 0);
        clear_v[k] = ($urandom_range(39, 0) == 0);
        mask_v[k]  = 2'($urandom_range(3, 0));
      end
      kind_v[0] = 1;
      kind_v[2] = 1;
      step();
    end
    idle_inputs();
    $display("txn random: %0d edges done, checks so far=%0d", n_edge, n_checks);

    // Asynchronous reset in the middle of a check run.
    for (int k = 0; k < NI; k++) clear_v[k] = 1'b1;
    step();
    for (int k = 0; k < NI; k++) clear_v[k] = 1'b0;
    arm_v[0] = 1'b1; step(); arm_v[0] = 1'b0;
    repeat (4) step();
    check_val("s040.pre_state", 128'(st_o[0]), 128'd2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) check_all(k);
    check_val("s040.state", 128'(st_o[0]), 128'd0);
    check_val("s040.cycle_cnt", 128'(cyc_o[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    check_val("s040.post_state", 128'(st_o[0]), 128'd0);
    $display("txn reset: state=%0d cycle_cnt=%0d", st_o[0], cyc_o[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
